// File: rtl/mem_req_arbiter_pkg.sv
// Shared types and encodings for the instruction/data memory request arbiter.
package mem_req_arbiter_pkg;

  localparam int unsigned SIZE_W = 2;

  localparam logic ID_INST = 1'b0;
  localparam logic ID_DATA = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOCK_INST = 2'd1,
    ST_LOCK_DATA = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_INST = 2'd1,
    GNT_DATA = 2'd2
  } arb_grant_e;

  typedef struct packed {
    logic              wr;
    logic [SIZE_W-1:0] size;
    logic [31:0]       addr;
    logic [3:0]        wstrb;
    logic [31:0]       wdata;
  } mem_cmd_t;

  function automatic arb_state_e lock_state(input arb_grant_e g);
    return (g == GNT_DATA) ? ST_LOCK_DATA : ST_LOCK_INST;
  endfunction

endpackage

// File: rtl/mem_req_arbiter_id_fifo.sv
// In-order FIFO of 1-bit requester IDs for accepted-but-unanswered requests.
module arb_id_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push_i,
  input  logic id_i,
  input  logic pop_i,
  output logic head_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [DEPTH-1:0] mem_q;
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      mem_q    <= '0;
    end else begin
      count_q <= count_d;
      if (do_push) begin
        mem_q[wr_ptr_q] <= id_i;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Two-master (inst/data) arbiter onto one pipelined memory port with in-order response routing.
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int unsigned OT_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [SIZE_W-1:0] inst_size,
  input  logic [31:0]       inst_addr,
  input  logic [3:0]        inst_wstrb,
  input  logic [31:0]       inst_wdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [31:0]       inst_rdata,

  input  logic              data_req,
  input  logic              data_wr,
  input  logic [SIZE_W-1:0] data_size,
  input  logic [31:0]       data_addr,
  input  logic [3:0]        data_wstrb,
  input  logic [31:0]       data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [31:0]       data_rdata,

  output logic              mem_req,
  output logic              mem_wr,
  output logic [SIZE_W-1:0] mem_size,
  output logic [31:0]       mem_addr,
  output logic [3:0]        mem_wstrb,
  output logic [31:0]       mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [31:0]       mem_rdata,

  output logic              err_unexp_data_ok
);

  arb_state_e state_q;
  logic       rst_seen_q;
  logic       err_q;

  arb_grant_e grant;
  logic       gnt_req;
  logic       blocked;
  logic       accept;
  logic       pop;
  mem_cmd_t   inst_cmd;
  mem_cmd_t   data_cmd;
  mem_cmd_t   sel_cmd;

  logic       ot_head;
  logic       ot_full;
  logic       ot_empty;

  always_comb begin
    grant = GNT_NONE;
    unique case (state_q)
      ST_IDLE: begin
        if (data_req)      grant = GNT_DATA;
        else if (inst_req) grant = GNT_INST;
        else               grant = GNT_NONE;
      end
      ST_LOCK_INST: grant = GNT_INST;
      ST_LOCK_DATA: grant = GNT_DATA;
      default:      grant = GNT_NONE;
    endcase
  end

  assign inst_cmd = '{wr: inst_wr, size: inst_size, addr: inst_addr,
                      wstrb: inst_wstrb, wdata: inst_wdata};
  assign data_cmd = '{wr: data_wr, size: data_size, addr: data_addr,
                      wstrb: data_wstrb, wdata: data_wdata};
  assign sel_cmd  = (grant == GNT_DATA) ? data_cmd : inst_cmd;

  assign gnt_req = ((grant == GNT_INST) & inst_req) | ((grant == GNT_DATA) & data_req);

  // The port stays quiet during reset and the first cycle after it.
  assign blocked = reset | rst_seen_q;

  assign mem_req   = gnt_req & ~ot_full & ~blocked;
  assign mem_wr    = sel_cmd.wr;
  assign mem_size  = sel_cmd.size;
  assign mem_addr  = sel_cmd.addr;
  assign mem_wstrb = sel_cmd.wstrb;
  assign mem_wdata = sel_cmd.wdata;

  assign accept       = mem_req & mem_addr_ok;
  assign inst_addr_ok = accept & (grant == GNT_INST);
  assign data_addr_ok = accept & (grant == GNT_DATA);

  assign pop          = mem_data_ok & ~ot_empty & ~reset;
  assign inst_data_ok = pop & (ot_head == ID_INST);
  assign data_data_ok = pop & (ot_head == ID_DATA);

  assign inst_rdata = mem_rdata;
  assign data_rdata = mem_rdata;

  assign err_unexp_data_ok = err_q;

  arb_id_fifo #(
    .DEPTH (OT_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (accept),
    .id_i    ((grant == GNT_DATA) ? ID_DATA : ID_INST),
    .pop_i   (pop),
    .head_o  (ot_head),
    .full_o  (ot_full),
    .empty_o (ot_empty)
  );

  // A granted requester that is not accepted this cycle keeps the port until accepted
  // or until it drops its request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      rst_seen_q <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      rst_seen_q <= 1'b0;
      if (mem_data_ok & ot_empty) begin
        err_q <= 1'b1;
      end
      unique case (state_q)
        ST_IDLE: begin
          if ((grant != GNT_NONE) && !accept) begin
            state_q <= lock_state(grant);
          end
        end
        ST_LOCK_INST: begin
          if (!inst_req || accept) state_q <= ST_IDLE;
        end
        ST_LOCK_DATA: begin
          if (!data_req || accept) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed and randomized checks of mem_req_arbiter against a queue-based reference model.
module tb_mem_req_arbiter;
  import mem_req_arbiter_pkg::*;

  localparam int OT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size, mem_size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic [3:0]  inst_wstrb, data_wstrb, mem_wstrb;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        err_unexp_data_ok;

  always #5 clk = ~clk;

  mem_req_arbiter #(.OT_DEPTH(OT)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .err_unexp_data_ok(err_unexp_data_ok)
  );

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  // Reference model: who owns the port (0 none, 1 inst, 2 data), outstanding IDs in order.
  int owner_lock = 0;
  bit id_q[$];
  bit err_m = 1'b0;
  bit after_rst = 1'b1;
  int own;
  bit oreq, e_req, e_acc, e_pop;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic settle_check();
    bit head;
    bit [31:0] e_addr;
    #4;
    own = (owner_lock != 0) ? owner_lock : (data_req ? 2 : (inst_req ? 1 : 0));
    oreq = (own == 1) ? inst_req : ((own == 2) ? data_req : 1'b0);
    e_req = oreq && (id_q.size() != OT) && !(reset || after_rst);
    e_acc = e_req && mem_addr_ok;
    e_pop = mem_data_ok && (id_q.size() != 0) && !reset;
    head = (id_q.size() != 0) ? id_q[0] : 1'b0;
    e_addr = (own == 2) ? data_addr : inst_addr;
    chk("mem_req", 32'(mem_req), 32'(e_req));
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wr", 32'(mem_wr), 32'((own == 2) ? data_wr : inst_wr));
    chk("mem_size", 32'(mem_size), 32'((own == 2) ? data_size : inst_size));
    chk("mem_wstrb", 32'(mem_wstrb), 32'((own == 2) ? data_wstrb : inst_wstrb));
    chk("mem_wdata", mem_wdata, (own == 2) ? data_wdata : inst_wdata);
    chk("inst_addr_ok", 32'(inst_addr_ok), 32'(e_acc && own == 1));
    chk("data_addr_ok", 32'(data_addr_ok), 32'(e_acc && own == 2));
    chk("inst_data_ok", 32'(inst_data_ok), 32'(e_pop && head == 1'b0));
    chk("data_data_ok", 32'(data_data_ok), 32'(e_pop && head == 1'b1));
    chk("inst_rdata", inst_rdata, mem_rdata);
    chk("data_rdata", data_rdata, mem_rdata);
    chk("err_unexp", 32'(err_unexp_data_ok), 32'(err_m));
    chk("ot_count", 32'(dut.u_fifo.count_q), 32'(id_q.size()));
  endtask

  task automatic advance();
    if (reset) begin
      owner_lock = 0;
      id_q.delete();
      err_m = 1'b0;
      after_rst = 1'b1;
    end else begin
      after_rst = 1'b0;
      if (mem_data_ok && id_q.size() == 0) err_m = 1'b1;
      if (e_pop) void'(id_q.pop_front());
      if (e_acc) id_q.push_back(own == 2);
      if (owner_lock == 0) begin
        if (own != 0 && !e_acc) owner_lock = own;
      end else if (!oreq || e_acc) begin
        owner_lock = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    settle_check();
    advance();
  endtask

  task automatic drv(input bit ir, input bit dr, input bit aok, input bit dok);
    inst_req = ir;
    data_req = dr;
    mem_addr_ok = aok;
    mem_data_ok = dok;
  endtask

  initial begin
    reset = 1'b1;
    inst_wr = 1'b0; inst_size = 2'd2; inst_addr = 32'h1c00_0000;
    inst_wstrb = 4'hf; inst_wdata = 32'h1111_1111;
    data_wr = 1'b1; data_size = 2'd1; data_addr = 32'h0000_1000;
    data_wstrb = 4'h3; data_wdata = 32'h2222_2222;
    mem_rdata = 32'h0;
    drv(0, 0, 0, 0);
    @(posedge clk);
    #1;
    step();
    reset = 1'b0;
    step();

    // Simultaneous requests: data wins, accepted at once, FSM stays idle.
    drv(1, 1, 1, 0);
    settle_check();
    chk("dir_both_addr", mem_addr, 32'h0000_1000);
    chk("dir_both_daok", 32'(data_addr_ok), 32'd1);
    chk("dir_both_iaok", 32'(inst_addr_ok), 32'd0);
    advance();
    chk("dir_both_idle", 32'(dut.state_q), 32'(ST_IDLE));
    drv(0, 0, 0, 1);
    step();

    // Inst granted and stalled; data arrives late and must wait.
    drv(1, 0, 0, 0);
    step();
    drv(1, 1, 0, 0);
    settle_check();
    chk("lock_addr_c2", mem_addr, 32'h1c00_0000);
    advance();
    settle_check();
    chk("lock_state", 32'(dut.state_q), 32'(ST_LOCK_INST));
    chk("lock_addr_c3", mem_addr, 32'h1c00_0000);
    advance();
    drv(1, 1, 1, 0);
    settle_check();
    chk("lock_iaok", 32'(inst_addr_ok), 32'd1);
    advance();
    drv(0, 1, 1, 0);
    settle_check();
    chk("lock_then_data", 32'(data_addr_ok), 32'd1);
    advance();
    drv(0, 0, 0, 1);
    step();
    step();

    // Fill the outstanding queue, then one response frees a slot.
    drv(1, 0, 1, 0);
    for (int i = 0; i < OT; i++) step();
    settle_check();
    chk("full_block", 32'(mem_req), 32'd0);
    advance();
    drv(1, 0, 1, 1);
    mem_rdata = 32'h0000_0055;
    settle_check();
    chk("full_pop_iok", 32'(inst_data_ok), 32'd1);
    chk("full_pop_block", 32'(mem_req), 32'd0);
    advance();
    drv(1, 0, 1, 0);
    settle_check();
    chk("full_freed", 32'(mem_req), 32'd1);
    advance();
    drv(0, 0, 0, 1);
    for (int i = 0; i < OT; i++) step();

    // Ordered responses for inst, data, inst.
    drv(1, 0, 1, 0); step();
    drv(0, 1, 1, 0); step();
    drv(1, 0, 1, 0); step();
    drv(0, 0, 0, 1);
    mem_rdata = 32'hA;
    settle_check(); chk("ord_1", {inst_data_ok, data_data_ok}, 32'b10); advance();
    mem_rdata = 32'hB;
    settle_check(); chk("ord_2", {inst_data_ok, data_data_ok}, 32'b01);
    chk("ord_rdata", data_rdata, 32'hB); advance();
    mem_rdata = 32'hC;
    settle_check(); chk("ord_3", {inst_data_ok, data_data_ok}, 32'b10); advance();
    drv(0, 0, 0, 0);
    settle_check(); chk("ord_empty", 32'(dut.u_fifo.count_q), 32'd0); advance();

    // Push and pop in the same cycle at count 2.
    drv(1, 0, 1, 0); step();
    drv(0, 1, 1, 0); step();
    drv(0, 1, 1, 1);
    settle_check(); chk("pp_pop_inst", 32'(inst_data_ok), 32'd1); advance();
    drv(0, 0, 0, 0);
    settle_check(); chk("pp_count", 32'(dut.u_fifo.count_q), 32'd2); advance();
    drv(0, 0, 0, 1);
    settle_check(); chk("pp_head_data", 32'(data_data_ok), 32'd1); advance();
    step();

    // Unexpected response, then reset with three outstanding.
    drv(0, 0, 0, 1);
    settle_check();
    chk("unexp_no_strobe", {inst_data_ok, data_data_ok}, 32'b00);
    advance();
    drv(0, 0, 0, 0);
    settle_check(); chk("unexp_sticky", 32'(err_unexp_data_ok), 32'd1); advance();
    drv(1, 0, 1, 0);
    for (int i = 0; i < 3; i++) step();
    reset = 1'b1;
    settle_check(); chk("rst_mreq", 32'(mem_req), 32'd0); advance();
    reset = 1'b0;
    settle_check();
    chk("rst_after_mreq", 32'(mem_req), 32'd0);
    chk("rst_count", 32'(dut.u_fifo.count_q), 32'd0);
    chk("rst_err_clr", 32'(err_unexp_data_ok), 32'd0);
    advance();
    drv(0, 0, 0, 1);
    settle_check();
    chk("rst_stale_resp", {inst_data_ok, data_data_ok}, 32'b00);
    advance();
    drv(0, 0, 0, 0);
    step();

    // Randomized traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      inst_req = ($urandom_range(0, 9) < 7);
      data_req = ($urandom_range(0, 9) < 5);
      inst_wr = 1'($urandom); inst_size = 2'($urandom); inst_addr = $urandom;
      inst_wstrb = 4'($urandom); inst_wdata = $urandom;
      data_wr = 1'($urandom); data_size = 2'($urandom); data_addr = $urandom;
      data_wstrb = 4'($urandom); data_wdata = $urandom;
      mem_addr_ok = 1'($urandom);
      mem_data_ok = ($urandom_range(0, 9) < 4);
      mem_rdata = $urandom;
      step();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
